sha_work_loader: RTL and testbench
==================================

Name: sha_work_loader

Overview:
- Upstream work-feed stage for the SHA-256d miner core.
- Accepts one mining job as a stream of 32-bit words: midstate, header tail and target.
- Latches the job into the wide operand buses the miner consumes, pulses the miner start, and supervises the search.
- Returns a single result record (found/exhausted, nonce, hash) over a valid/ready handshake.

Parameters:
- JOB_WORDS, 19, words per job: 8 midstate + 3 header tail + 8 target.
- DRAIN_CYCLES, 160, cycles to keep watching miner_found after miner_done, covering in-flight pipeline hashes.
- CNT_W, 8, width of the drain counter; must satisfy 2^CNT_W > DRAIN_CYCLES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- s_data  in  32  job word.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final job word.
- s_ready  out  1  loader accepts a word this cycle.
- prev_H  out  256  midstate to miner.
- input_M  out  96  header tail (merkle tail, time, bits) to miner.
- prev_blk  out  256  target to miner.
- miner_en  out  1  one-cycle start pulse to miner.
- miner_rst  out  1  active-high synchronous reset to miner; holds it idle.
- miner_done  in  1  miner nonce space exhausted.
- miner_found  in  1  miner hash below target.
- miner_nonce  in  32  winning nonce.
- miner_H  in  256  winning hash.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the record.
- res_found  out  1  1 = winning nonce, 0 = exhausted.
- res_nonce  out  32  winning nonce; 0 when not found.
- res_H  out  256  winning hash; 0 when not found.
- job_err  out  1  one-cycle pulse on a malformed job.
- busy  out  1  high in every state except LOAD.

Behaviour:
- Reset (async assert, sync deassert):
  - state = LOAD, word index = 0.
  - All output buses = 0.
  - miner_rst = 1, miner_en = 0, res_valid = 0, job_err = 0, s_ready = 1, busy = 0.
- FSM states: LOAD, START, RUN, DRAIN, REPORT.
- LOAD:
  - miner_rst = 1, s_ready = 1.
  - Each s_valid beat writes word k (k = index): words 0-7 fill prev_H MSB-first (word 0 -> [255:224]); words 8-10 fill input_M MSB-first; words 11-18 fill prev_blk MSB-first.
  - s_last with k == JOB_WORDS-1 -> START.
  - s_last with k != JOB_WORDS-1 -> job_err pulse, index = 0, stay in LOAD. Partial operands may be left in place; they are overwritten by the next job.
  - Beat at k == JOB_WORDS-1 without s_last -> same job_err handling.
- START:
  - Exactly one cycle; miner_rst = 0, miner_en = 1, s_ready = 0 -> RUN.
  - miner_rst falls the same cycle miner_en rises. The miner samples en with reset low, so the first nonce launches on the next edge.
- RUN:
  - miner_found -> capture miner_nonce and miner_H, res_found = 1 -> REPORT.
  - miner_done without found -> clear drain counter -> DRAIN.
  - found and done in the same cycle -> found wins.
- DRAIN:
  - Counter increments each cycle.
  - miner_found -> capture as in RUN -> REPORT.
  - Counter reaches DRAIN_CYCLES-1 -> res_found = 0, res_nonce = 0, res_H = 0 -> REPORT.
- REPORT:
  - miner_rst = 1, which stops the search.
  - res_valid = 1; the record stays stable until res_ready.
  - On the res_valid && res_ready handshake: res_valid = 0, index = 0 -> LOAD.
  - Later miner_found pulses are ignored; only the first found is reported.
- Operand buses hold their values from START through REPORT. s_ready = 0 outside LOAD, so job words arriving mid-search are back-pressured, not dropped.
- Latency: last job beat -> miner_en = 1 cycle; miner_found -> res_valid = 1 cycle.
- Reset mid-operation: everything returns to reset values immediately. The in-flight record is lost. miner_rst = 1 within the same cycle (combinational from state).
- miner_rst and miner_en are registered or decoded from registered state; no input-to-output combinational path.

Decomposition:
- Word, hash and input widths (WORD_S = 32, H_SIZE = 256, INPUT_S = 96) come from the existing shared sha header. Add JOB_WORDS there.
- Add the state encodings there as localparams.
- One natural sub-module: sha_job_shifter, the indexed word-to-operand write decoder with the job_err length check. The FSM and result capture stay in the top.

Test Plan:
1. Good job, words 0x00000000..0x00000012 with s_last on word 18 -> miner_en pulses 1 cycle later; prev_H[255:224] = 0, input_M = {8,9,10}, prev_blk[31:0] = 0x12.
2. Model asserts miner_found at RUN cycle 50 with nonce 0x43F740C5 -> res_valid next cycle, res_found = 1, res_nonce = 0x43F740C5; a second found 3 cycles later does not alter the record.
3. miner_done at cycle 40, no found -> res_valid after DRAIN_CYCLES (160) cycles, res_found = 0, res_nonce = 0, res_H = 0.
4. miner_done, then miner_found 20 cycles into DRAIN -> res_found = 1 with that nonce.
5. s_last on word 10 -> job_err pulse, no miner_en, s_ready stays 1; a following good job runs normally.
6. res_ready held low for 30 cycles -> res_valid and record stable, s_ready = 0. Reset pulse mid-RUN -> miner_rst = 1, res_valid = 0, state LOAD.

Source files
------------

// File: rtl/sha_work_loader_pkg.sv
// -----------------------------------------------------------------------------
// sha_work_loader_pkg
// Shared SHA-256d definitions for the miner work feed: word, hash and header
// tail widths, the job length in words, and the loader FSM state encodings.
// -----------------------------------------------------------------------------
package sha_work_loader_pkg;

   localparam int WORD_S    = 32;   // stream word width
   localparam int H_SIZE    = 256;  // hash / midstate / target width
   localparam int INPUT_S   = 96;   // header tail: merkle tail, time, bits
   localparam int JOB_WORDS = 19;   // 8 midstate + 3 header tail + 8 target

   localparam int H_WORDS = H_SIZE / WORD_S;   // words per 256-bit operand
   localparam int M_WORDS = INPUT_S / WORD_S;  // words in the header tail
   localparam int IDX_W   = 5;                 // word index width, holds 0..18

   // Loader FSM encodings
   localparam logic [2:0] ST_LOAD   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_REPORT = 3'd4;

   typedef enum logic [2:0] {
      S_LOAD   = ST_LOAD,
      S_START  = ST_START,
      S_RUN    = ST_RUN,
      S_DRAIN  = ST_DRAIN,
      S_REPORT = ST_REPORT
   } state_e;

endpackage

// File: rtl/sha_job_shifter.sv
// -----------------------------------------------------------------------------
// sha_job_shifter
// Indexed word-to-operand write decoder for one mining job. Each accepted beat
// writes stream word k into its slot (0-7 prev_H, 8-10 input_M, 11-18
// prev_blk, each MSB-first) and checks the job length against s_last.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   load_en          loader is in LOAD and accepting words
//   s_data/s_valid/s_last  job word stream
//   prev_H/input_M/prev_blk  latched operand buses
//   job_ok           combinational: final beat of a well-formed job this cycle
//   job_err          registered one-cycle pulse after a malformed job
// -----------------------------------------------------------------------------
module sha_job_shifter
   import sha_work_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_en,
   input  logic [WORD_S-1:0]    s_data,
   input  logic                 s_valid,
   input  logic                 s_last,
   output logic [H_SIZE-1:0]    prev_H,
   output logic [INPUT_S-1:0]   input_M,
   output logic [H_SIZE-1:0]    prev_blk,
   output logic                 job_ok,
   output logic                 job_err
);

   logic [IDX_W-1:0]   idx_q,      idx_d;
   logic [H_SIZE-1:0]  prev_h_q,   prev_h_d;
   logic [INPUT_S-1:0] input_m_q,  input_m_d;
   logic [H_SIZE-1:0]  prev_blk_q, prev_blk_d;
   logic               job_err_q,  job_err_d;

   logic beat;
   logic at_end;

   assign beat   = load_en && s_valid;
   assign at_end = (idx_q == IDX_W'(JOB_WORDS - 1));

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      idx_d      = idx_q;
      prev_h_d   = prev_h_q;
      input_m_d  = input_m_q;
      prev_blk_d = prev_blk_q;
      job_err_d  = 1'b0;
      job_ok     = 1'b0;

      if (beat) begin
         for (int w = 0; w < H_WORDS; w++) begin
            if (idx_q == IDX_W'(w))
               prev_h_d[(H_WORDS-1-w)*WORD_S +: WORD_S] = s_data;
         end
         for (int w = 0; w < M_WORDS; w++) begin
            if (idx_q == IDX_W'(H_WORDS + w))
               input_m_d[(M_WORDS-1-w)*WORD_S +: WORD_S] = s_data;
         end
         for (int w = 0; w < H_WORDS; w++) begin
            if (idx_q == IDX_W'(H_WORDS + M_WORDS + w))
               prev_blk_d[(H_WORDS-1-w)*WORD_S +: WORD_S] = s_data;
         end

         // s_last and the final index must coincide; either one alone is a bad job.
         if (s_last && at_end) begin
            job_ok = 1'b1;
            idx_d  = '0;
         end else if (s_last || at_end) begin
            job_err_d = 1'b1;
            idx_d     = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else if (!load_en) begin
         idx_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   // NOTE: operand registers are plain flops, not a memory array, so they take the reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q      <= '0;
         prev_h_q   <= '0;
         input_m_q  <= '0;
         prev_blk_q <= '0;
         job_err_q  <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         prev_h_q   <= prev_h_d;
         input_m_q  <= input_m_d;
         prev_blk_q <= prev_blk_d;
         job_err_q  <= job_err_d;
      end
   end

   assign prev_H   = prev_h_q;
   assign input_M  = input_m_q;
   assign prev_blk = prev_blk_q;
   assign job_err  = job_err_q;

endmodule

// File: rtl/sha_work_loader.sv
// -----------------------------------------------------------------------------
// sha_work_loader
// Work-feed stage for the SHA-256d miner core. Loads one job from a 32-bit
// word stream, pulses the miner start, watches for a winning nonce (including
// a drain window after the nonce space is exhausted) and returns one result
// record over a valid/ready handshake.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready  job word stream
//   prev_H/input_M/prev_blk     operand buses to the miner
//   miner_en/miner_rst          start pulse and idle-hold reset to the miner
//   miner_done/found/nonce/H    miner status and winning result
//   res_valid/res_ready         result record handshake
//   res_found/res_nonce/res_H   result record
//   job_err                     one-cycle pulse on a malformed job
//   busy                        high whenever not loading
// -----------------------------------------------------------------------------
module sha_work_loader
   import sha_work_loader_pkg::*;
#(
   parameter int DRAIN_CYCLES = 160,
   parameter int CNT_W        = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_S-1:0]    s_data,
   input  logic                 s_valid,
   input  logic                 s_last,
   output logic                 s_ready,
   output logic [H_SIZE-1:0]    prev_H,
   output logic [INPUT_S-1:0]   input_M,
   output logic [H_SIZE-1:0]    prev_blk,
   output logic                 miner_en,
   output logic                 miner_rst,
   input  logic                 miner_done,
   input  logic                 miner_found,
   input  logic [WORD_S-1:0]    miner_nonce,
   input  logic [H_SIZE-1:0]    miner_H,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_found,
   output logic [WORD_S-1:0]    res_nonce,
   output logic [H_SIZE-1:0]    res_H,
   output logic                 job_err,
   output logic                 busy
);

   state_e             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               res_found_q, res_found_d;
   logic [WORD_S-1:0]  res_nonce_q, res_nonce_d;
   logic [H_SIZE-1:0]  res_h_q,     res_h_d;

   logic load_en;
   logic job_ok;

   assign load_en = (state_q == S_LOAD);

   sha_job_shifter u_shifter (
      .clk      (clk),
      .reset    (reset),
      .load_en  (load_en),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .prev_H   (prev_H),
      .input_M  (input_M),
      .prev_blk (prev_blk),
      .job_ok   (job_ok),
      .job_err  (job_err)
   );

   // Next state and result capture. Found is tested before done and before
   // the drain timeout so a hit in the same cycle always wins.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      res_found_d = res_found_q;
      res_nonce_d = res_nonce_q;
      res_h_d     = res_h_q;

      unique case (state_q)
         S_LOAD: begin
            if (job_ok) state_d = S_START;
         end
         S_START: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (miner_found) begin
               res_found_d = 1'b1;
               res_nonce_d = miner_nonce;
               res_h_d     = miner_H;
               state_d     = S_REPORT;
            end else if (miner_done) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Hashes still in the miner pipeline may hit after done.
            if (miner_found) begin
               res_found_d = 1'b1;
               res_nonce_d = miner_nonce;
               res_h_d     = miner_H;
               state_d     = S_REPORT;
            end else if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
               res_found_d = 1'b0;
               res_nonce_d = '0;
               res_h_d     = '0;
               state_d     = S_REPORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_REPORT: begin
            if (res_ready) state_d = S_LOAD;
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_LOAD;
         cnt_q       <= '0;
         res_found_q <= 1'b0;
         res_nonce_q <= '0;
         res_h_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         res_found_q <= res_found_d;
         res_nonce_q <= res_nonce_d;
         res_h_q     <= res_h_d;
      end
   end

   // Control outputs decode registered state only, so reset forces
   // miner_rst high immediately and no input reaches an output combinationally.
   always_comb begin
      s_ready   = (state_q == S_LOAD);
      miner_en  = (state_q == S_START);
      miner_rst = (state_q == S_LOAD) || (state_q == S_REPORT);
      res_valid = (state_q == S_REPORT);
      busy      = (state_q != S_LOAD);
   end

   assign res_found = res_found_q;
   assign res_nonce = res_nonce_q;
   assign res_H     = res_h_q;

endmodule

// File: tb/tb_sha_work_loader.sv
// -----------------------------------------------------------------------------
// tb_sha_work_loader
// Self-checking bench: a job-level reference model tracks which phase the
// loader must be in, the words it has been given and the record it must
// return; a negedge compare process checks every output each cycle, and
// directed scenarios pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_sha_work_loader;
   import sha_work_loader_pkg::*;

   localparam int DRAIN = 160;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [WORD_S-1:0]   s_data = '0;
   logic                s_valid = 1'b0;
   logic                s_last = 1'b0;
   logic                s_ready;
   logic [H_SIZE-1:0]   prev_H;
   logic [INPUT_S-1:0]  input_M;
   logic [H_SIZE-1:0]   prev_blk;
   logic                miner_en;
   logic                miner_rst;
   logic                miner_done = 1'b0;
   logic                miner_found = 1'b0;
   logic [WORD_S-1:0]   miner_nonce = '0;
   logic [H_SIZE-1:0]   miner_H = '0;
   logic                res_valid;
   logic                res_ready = 1'b0;
   logic                res_found;
   logic [WORD_S-1:0]   res_nonce;
   logic [H_SIZE-1:0]   res_H;
   logic                job_err;
   logic                busy;

   always #5 clk = ~clk;

   sha_work_loader #(.DRAIN_CYCLES(DRAIN), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .prev_H      (prev_H),
      .input_M     (input_M),
      .prev_blk    (prev_blk),
      .miner_en    (miner_en),
      .miner_rst   (miner_rst),
      .miner_done  (miner_done),
      .miner_found (miner_found),
      .miner_nonce (miner_nonce),
      .miner_H     (miner_H),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_found   (res_found),
      .res_nonce   (res_nonce),
      .res_H       (res_H),
      .job_err     (job_err),
      .busy        (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_ARMED, M_SEARCH, M_REPORT} mphase_e;

   mphase_e            m_phase;
   logic [31:0]        m_words [JOB_WORDS];
   int                 m_idx;
   int                 m_cyc;
   int                 m_done_cyc;
   bit                 m_done_seen;
   bit                 m_err;
   bit                 m_found;
   logic [31:0]        m_nonce;
   logic [255:0]       m_H;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase     <= M_IDLE;
         m_idx       <= 0;
         m_cyc       <= 0;
         m_done_cyc  <= 0;
         m_done_seen <= 1'b0;
         m_err       <= 1'b0;
         m_found     <= 1'b0;
         m_nonce     <= '0;
         m_H         <= '0;
         for (int i = 0; i < JOB_WORDS; i++) m_words[i] <= '0;
      end else begin
         m_err <= 1'b0;
         m_cyc <= m_cyc + 1;
         case (m_phase)
            M_IDLE: if (s_valid) begin
               m_words[m_idx] <= s_data;
               if (s_last && m_idx == JOB_WORDS - 1) begin
                  m_phase <= M_ARMED;
                  m_idx   <= 0;
               end else if (s_last || m_idx == JOB_WORDS - 1) begin
                  m_err <= 1'b1;
                  m_idx <= 0;
               end else begin
                  m_idx <= m_idx + 1;
               end
            end
            M_ARMED: begin
               m_phase     <= M_SEARCH;
               m_done_seen <= 1'b0;
            end
            M_SEARCH: begin
               if (miner_found) begin
                  m_found <= 1'b1;
                  m_nonce <= miner_nonce;
                  m_H     <= miner_H;
                  m_phase <= M_REPORT;
               end else if (m_done_seen && (m_cyc - m_done_cyc) == DRAIN) begin
                  m_found <= 1'b0;
                  m_nonce <= '0;
                  m_H     <= '0;
                  m_phase <= M_REPORT;
               end else if (!m_done_seen && miner_done) begin
                  m_done_seen <= 1'b1;
                  m_done_cyc  <= m_cyc;
               end
            end
            M_REPORT: if (res_ready) m_phase <= M_IDLE;
            default: m_phase <= M_IDLE;
         endcase
      end
   end

   function automatic logic [255:0] words8(input int base);
      logic [255:0] r = '0;
      for (int i = 0; i < 8; i++) r = {r[223:0], m_words[base + i]};
      return r;
   endfunction

   bit cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en) begin
         check("s_ready",   s_ready,   m_phase == M_IDLE);
         check("busy",      busy,      m_phase != M_IDLE);
         check("miner_en",  miner_en,  m_phase == M_ARMED);
         check("miner_rst", miner_rst, (m_phase == M_IDLE) || (m_phase == M_REPORT));
         check("res_valid", res_valid, m_phase == M_REPORT);
         check("job_err",   job_err,   m_err);
         check("prev_H",    prev_H,    words8(0));
         check("input_M",   input_M,   {m_words[8], m_words[9], m_words[10]});
         check("prev_blk",  prev_blk,  words8(11));
         if (m_phase == M_REPORT) begin
            check("res_found", res_found, m_found);
            check("res_nonce", res_nonce, m_nonce);
            check("res_H",     res_H,     m_H);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [31:0] job_w [JOB_WORDS];

   function automatic logic [255:0] rand256();
      logic [255:0] r = '0;
      for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_job();
      for (int k = 0; k < JOB_WORDS; k++) job_w[k] = $urandom();
   endtask

   task automatic send_job(input int n, input int last_at, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
         end
         s_valid = 1'b1;
         s_data  = job_w[k];
         s_last  = (k == last_at);
         begin
            int t = 0;
            while (!s_ready && t < 100) begin
               tick();
               t++;
            end
            if (!s_ready) check("s_ready_wait", s_ready, 1'b1);
         end
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic pulse_found(input logic [31:0] n, input logic [255:0] h);
      miner_found = 1'b1;
      miner_nonce = n;
      miner_H     = h;
      tick();
      miner_found = 1'b0;
   endtask

   task automatic pulse_done();
      miner_done = 1'b1;
      tick();
      miner_done = 1'b0;
   endtask

   task automatic wait_res(input int budget);
      int t = 0;
      while (!res_valid && t < budget) begin
         tick();
         t++;
      end
      check("res_valid_wait", res_valid, 1'b1);
   endtask

   task automatic handshake(input int delay);
      repeat (delay) tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scenarios ----------------
   initial begin
      logic [255:0] h;
      int           n;

      tick();
      cmp_en = 1'b1;
      tick();
      check("rst_s_ready",   s_ready,   1'b1);
      check("rst_miner_rst", miner_rst, 1'b1);
      check("rst_miner_en",  miner_en,  1'b0);
      check("rst_busy",      busy,      1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_prev_H",    prev_H,    '0);
      check("rst_res_nonce", res_nonce, '0);
      reset = 1'b1;
      tick();

      // 1: counting job, miner_en one cycle after the last beat
      for (int k = 0; k < JOB_WORDS; k++) job_w[k] = 32'(k);
      send_job(JOB_WORDS, JOB_WORDS - 1, 1'b0);
      check("t1_miner_en",   miner_en,          1'b1);
      check("t1_prev_H_top", prev_H[255:224],   32'h0);
      check("t1_prev_H_low", prev_H[31:0],      32'h7);
      check("t1_input_M",    input_M,           96'h00000008_00000009_0000000A);
      check("t1_prev_blk",   prev_blk[31:0],    32'h12);
      tick();
      check("t1_miner_en_off", miner_en, 1'b0);

      // 2: found at RUN cycle 50, later found ignored
      repeat (49) tick();
      h = rand256();
      pulse_found(32'h43F740C5, h);
      check("t2_res_valid", res_valid, 1'b1);
      check("t2_res_found", res_found, 1'b1);
      check("t2_res_nonce", res_nonce, 32'h43F740C5);
      check("t2_res_H",     res_H,     h);
      repeat (2) tick();
      pulse_found(32'hDEADBEEF, rand256());
      check("t2_nonce_kept", res_nonce, 32'h43F740C5);
      handshake(0);
      check("t2_back_load", s_ready, 1'b1);

      // 3: exhausted, drain runs its full length
      rand_job();
      send_job(JOB_WORDS, JOB_WORDS - 1, 1'b1);
      tick();
      repeat (39) tick();
      pulse_done();
      n = 0;
      while (!res_valid && n < 300) begin
         tick();
         n++;
      end
      check("t3_drain_len", n,         DRAIN);
      check("t3_res_found", res_found, 1'b0);
      check("t3_res_nonce", res_nonce, '0);
      check("t3_res_H",     res_H,     '0);
      handshake(1);

      // 4: found 20 cycles into drain
      rand_job();
      send_job(JOB_WORDS, JOB_WORDS - 1, 1'b0);
      tick();
      repeat (10) tick();
      pulse_done();
      repeat (19) tick();
      pulse_found(32'h0BADF00D, rand256());
      check("t4_res_valid", res_valid, 1'b1);
      check("t4_res_found", res_found, 1'b1);
      check("t4_res_nonce", res_nonce, 32'h0BADF00D);
      handshake(2);

      // 5: short job, then a 19-beat job without s_last, then a good job
      rand_job();
      send_job(11, 10, 1'b0);
      check("t5_job_err",   job_err, 1'b1);
      check("t5_s_ready",   s_ready, 1'b1);
      tick();
      check("t5_err_pulse", job_err, 1'b0);
      repeat (3) tick();
      check("t5_no_start",  busy,    1'b0);
      rand_job();
      send_job(JOB_WORDS, -1, 1'b0);
      check("t5_no_last_err", job_err, 1'b1);
      rand_job();
      send_job(JOB_WORDS, JOB_WORDS - 1, 1'b1);
      check("t5_good_en", miner_en, 1'b1);
      tick();
      repeat (7) tick();
      pulse_found(32'h12345678, rand256());
      check("t5_res_nonce", res_nonce, 32'h12345678);
      handshake(0);

      // 6: held record, then reset mid-RUN
      rand_job();
      send_job(JOB_WORDS, JOB_WORDS - 1, 1'b0);
      tick();
      pulse_found(32'hCAFE0001, rand256());
      repeat (30) tick();
      check("t6_hold_valid", res_valid, 1'b1);
      check("t6_hold_nonce", res_nonce, 32'hCAFE0001);
      check("t6_hold_ready", s_ready,   1'b0);
      handshake(0);
      rand_job();
      send_job(JOB_WORDS, JOB_WORDS - 1, 1'b0);
      repeat (20) tick();
      reset = 1'b0;
      #1;
      check("t6_rst_miner_rst", miner_rst, 1'b1);
      check("t6_rst_res_valid", res_valid, 1'b0);
      check("t6_rst_s_ready",   s_ready,   1'b1);
      check("t6_rst_busy",      busy,      1'b0);
      check("t6_rst_prev_H",    prev_H,    '0);
      tick();
      reset = 1'b1;
      tick();

      // randomized jobs
      for (int r = 0; r < 14; r++) begin
         int mode = $urandom_range(0, 4);
         rand_job();
         if (mode == 4) begin
            if ($urandom_range(0, 1) == 1) begin
               int len = $urandom_range(1, JOB_WORDS - 1);
               send_job(len, len - 1, 1'b1);
            end else begin
               send_job(JOB_WORDS, -1, 1'b1);
            end
            tick();
         end else begin
            send_job(JOB_WORDS, JOB_WORDS - 1, 1'b1);
            tick();
            case (mode)
               0: begin
                  repeat ($urandom_range(0, 60)) tick();
                  pulse_found($urandom(), rand256());
                  wait_res(2);
               end
               1: begin
                  repeat ($urandom_range(0, 40)) tick();
                  pulse_done();
                  wait_res(DRAIN + 10);
               end
               2: begin
                  repeat ($urandom_range(0, 20)) tick();
                  pulse_done();
                  repeat ($urandom_range(0, DRAIN - 1)) tick();
                  pulse_found($urandom(), rand256());
                  wait_res(5);
                  check("rnd_drain_found", res_found, 1'b1);
               end
               default: begin
                  repeat ($urandom_range(0, 30)) tick();
                  miner_found = 1'b1;
                  miner_done  = 1'b1;
                  miner_nonce = $urandom();
                  miner_H     = rand256();
                  tick();
                  miner_found = 1'b0;
                  miner_done  = 1'b0;
                  check("rnd_found_wins", res_found, 1'b1);
               end
            endcase
            handshake($urandom_range(0, 5));
         end
      end

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
